modulo_cuenta_regresiva: RTL and testbench



---
 rtl/modulo_cuenta_regresiva.sv | 109 ++++++++++
 tb/tb_modulo_cuenta_regresiva.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_cuenta_regresiva.sv
// rtl/modulo_cuenta_regresiva.sv - Loadable prescaled countdown timer with one-cycle done pulse.
// Optional periodic mode: define MODULO_CUENTA_REGRESIVA_AUTO_RELOAD_EN.
module modulo_cuenta_regresiva #(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state_q, state_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             busy_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_o  <= '0;
      reload_q <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_n;
      presc_q  <= presc_n;
      count_o  <= count_n;
      reload_q <= reload_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    count_n  = count_o;
    reload_n = reload_q;
    done_n   = 1'b0;

    if (load_i) begin
      // Loading always aborts whatever is in progress, silently.
      state_n  = IDLE;
      presc_n  = '0;
      count_n  = value_i;
      reload_n = value_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            presc_n = '0;
            if (count_o == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = RUN;
            end
          end
        end
        RUN, HOLD: begin
          // A resuming HOLD edge counts like a RUN edge, so a pause costs exactly its own edges.
          if (pause_i) begin
            state_n = HOLD;
          end else begin
            state_n = RUN;
            if (presc_q == PRESC_LAST) begin
              presc_n = '0;
              if (count_o == WIDTH'(1)) begin
                done_n = 1'b1;
`ifdef MODULO_CUENTA_REGRESIVA_AUTO_RELOAD_EN
                count_n = reload_q;
`else
                count_n = '0;
                state_n = DONE;
`endif
              end else begin
                count_n = count_o - WIDTH'(1);
              end
            end else begin
              presc_n = presc_q + PW'(1);
            end
          end
        end
        DONE: begin
          count_n = '0;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n == RUN) || (state_n == HOLD);
  end

endmodule

// File: tb/tb_modulo_cuenta_regresiva.sv
// tb/tb_modulo_cuenta_regresiva.sv - Self-checking bench for modulo_cuenta_regresiva.
module tb_modulo_cuenta_regresiva;
  localparam int WIDTH    = 6;
  localparam int PRESCALE = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_i = 1'b0;
  logic [WIDTH-1:0] value_i = '0;
  logic             start_i = 1'b0;
  logic             pause_i = 1'b0;
  logic [WIDTH-1:0] count_o;
  logic             busy_o;
  logic             done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0=idle 1=running(or paused) 2=done; count derived from active edges.
  int m_phase  = 0;
  int m_n      = 0;
  int m_active = 0;
  int m_count  = 0;
  bit m_done   = 1'b0;

  modulo_cuenta_regresiva #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i),
    .start_i(start_i), .pause_i(pause_i),
    .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      m_phase = 0; m_n = 0; m_active = 0; m_count = 0;
    end else if (load_i) begin
      m_phase = 0; m_n = int'(value_i); m_active = 0; m_count = int'(value_i);
    end else if (m_phase == 0) begin
      if (start_i) begin
        m_active = 0;
        if (m_count == 0) begin
          m_phase = 2; m_done = 1'b1;
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 1 && !pause_i) begin
      m_active++;
`ifdef MODULO_CUENTA_REGRESIVA_AUTO_RELOAD_EN
      m_count = m_n - (m_active / PRESCALE) % m_n;
      m_done  = (m_active % (m_n * PRESCALE)) == 0;
`else
      m_count = m_n - m_active / PRESCALE;
      if (m_active == m_n * PRESCALE) begin
        m_phase = 2; m_done = 1'b1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; load_i = 1'b0; start_i = 1'b0; pause_i = 1'b0;
  endtask

  task automatic load_and_start(input int v);
    quiet_inputs();
    load_i = 1'b1; value_i = WIDTH'(v);
    tick();
    load_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(0), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_initial: count=%0d busy=%0b done=%0b, required 0/0/0", count_o, busy_o, done_o);
      end
    end
    load_and_start(25);
    repeat (50) tick();
    n_checks++;
    if (count_o !== WIDTH'(20) || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: count=%0d busy=%0b, required 20/1", count_o, busy_o);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(0), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_midrun[%0d]: count=%0d busy=%0b done=%0b, required 0/0/0", i, count_o, busy_o, done_o);
      end
    end
    quiet_inputs();
    repeat (5) tick();
    n_checks++;
    if ({count_o, busy_o, done_o} !== {WIDTH'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_after: count=%0d busy=%0b done=%0b, required 0/0/0", count_o, busy_o, done_o);
    end
  endtask

  task automatic test_countdown();
    int exp_c;
    load_and_start(5);
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp_c = (k < 50) ? 5 - k / 10 : 0;
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(exp_c), k < 50, k == 50}) begin
        n_fail++;
        $display("FAIL countdown k=%0d: count=%0d busy=%0b done=%0b, required %0d/%0b/%0b",
                 k, count_o, busy_o, done_o, exp_c, k < 50, k == 50);
      end
    end
  endtask

  task automatic test_pause();
    int act, paused, exp_c;
    load_and_start(5);
    for (int k = 1; k <= 90; k++) begin
      pause_i = (k >= 13 && k <= 37);
      tick();
      paused = (k < 13) ? 0 : ((k > 37 ? 37 : k) - 12);
      act    = k - paused;
      exp_c  = (act < 50) ? 5 - act / 10 : 0;
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(exp_c), k < 75, k == 75}) begin
        n_fail++;
        $display("FAIL pause k=%0d: count=%0d busy=%0b done=%0b, required %0d/%0b/%0b",
                 k, count_o, busy_o, done_o, exp_c, k < 75, k == 75);
      end
    end
    pause_i = 1'b0;
  endtask

  task automatic test_zero_start();
    load_and_start(0);
    n_checks++;
    if ({count_o, busy_o, done_o} !== {WIDTH'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_start: count=%0d busy=%0b done=%0b, required 0/0/1", count_o, busy_o, done_o);
    end
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(0), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_after[%0d]: count=%0d busy=%0b done=%0b, required 0/0/0", i, count_o, busy_o, done_o);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_abort();
    load_and_start(40);
    repeat (70) tick();
    n_checks++;
    if (count_o !== WIDTH'(33)) begin
      n_fail++;
      $display("FAIL abort_pre: count=%0d, required 33", count_o);
    end
    load_i = 1'b1; value_i = WIDTH'(63);
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(63), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL abort[%0d]: count=%0d busy=%0b done=%0b, required 63/0/0", i, count_o, busy_o, done_o);
      end
      tick();
    end
  endtask

`ifdef MODULO_CUENTA_REGRESIVA_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int exp_c;
    load_and_start(3);
    for (int k = 1; k <= 95; k++) begin
      tick();
      exp_c = 3 - (k / 10) % 3;
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(exp_c), 1'b1, (k % 30) == 0}) begin
        n_fail++;
        $display("FAIL auto_reload k=%0d: count=%0d busy=%0b done=%0b, required %0d/1/%0b",
                 k, count_o, busy_o, done_o, exp_c, (k % 30) == 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom % 300) == 0;
      load_i  = ($urandom % 60) == 0;
      value_i = (($urandom % 8) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      start_i = ($urandom % 4) == 0;
      if (($urandom % 8) == 0) pause_i = ~pause_i;
      tick();
      n_checks++;
      if ({count_o, busy_o, done_o} !== {WIDTH'(m_count), m_phase == 1, m_done}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random i=%0d: count=%0d busy=%0b done=%0b, required %0d/%0b/%0b",
                   i, count_o, busy_o, done_o, m_count, m_phase == 1, m_done);
      end
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_zero_start();
    test_abort();
`ifdef MODULO_CUENTA_REGRESIVA_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
